// File: rtl/exotiny_pkg.sv
// Shared types and constants for the exotiny instruction prefetch path.
package exotiny_pkg;

  localparam int WORDW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PREF  = 2'd2
  } pf_state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_iprefetch.sv
// One-line instruction prefetch buffer between the CPU imem port and the QSPI read path.
// state | meaning
// IDLE  | serve hits, launch demand reads or background line refill
// FETCH | demand read in flight, data forwarded to the CPU on mem_ack_i
// PREF  | speculative read of the lowest invalid word of the current line
module wb_iprefetch
  import exotiny_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADRW  = 22
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_stb_i,
  input  logic [ADRW-1:0]  cpu_adr_i,
  output logic [WORDW-1:0] cpu_dat_o,
  output logic             cpu_ack_o,
  output logic             mem_stb_o,
  output logic [ADRW-1:0]  mem_adr_o,
  input  logic [WORDW-1:0] mem_dat_i,
  input  logic             mem_ack_i,
  input  logic             dmem_req_i,
  input  logic             inv_i
);

  localparam int IDXW = idx_width(DEPTH);
  localparam int TAGW = ADRW - IDXW;

  pf_state_e        state_q, state_d;
  logic [TAGW-1:0]  tag_q;
  logic             line_valid_q;
  logic [DEPTH-1:0] valid_q;
  logic [WORDW-1:0] data_q [DEPTH];
  logic             hit_ack_q, ack_prev_q, dmem_q, inv_pend_q;
  logic [WORDW-1:0] dat_q;
  logic             mem_stb_q;
  logic [ADRW-1:0]  mem_adr_q;

  logic [TAGW-1:0]  cpu_tag;
  logic [IDXW-1:0]  cpu_idx, mem_idx, pf_idx;
  logic             tag_hit, hit, busy, pf_need;
  logic             start_fetch, start_pref, new_line, hit_now, fwd, store;

  assign cpu_tag = cpu_adr_i[ADRW-1:IDXW];
  assign cpu_idx = cpu_adr_i[IDXW-1:0];
  assign mem_idx = mem_adr_q[IDXW-1:0];
  assign tag_hit = line_valid_q && (cpu_tag == tag_q);
  assign hit     = tag_hit && valid_q[cpu_idx] && !inv_i;
  // A request still held high during or right after its ack must not be served twice.
  assign busy    = hit_ack_q || ack_prev_q;
  assign pf_need = ~&valid_q;

  always_comb begin
    pf_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) pf_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    start_pref  = 1'b0;
    new_line    = 1'b0;
    hit_now     = 1'b0;
    fwd         = 1'b0;
    store       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_stb_i && !busy) begin
          if (hit) begin
            hit_now = 1'b1;
          end else begin
            start_fetch = 1'b1;
            new_line    = !tag_hit;
            state_d     = FETCH;
          end
        end else if (!cpu_stb_i && !dmem_req_i && !dmem_q && !inv_i &&
                     line_valid_q && pf_need) begin
          start_pref = 1'b1;
          state_d    = PREF;
        end
      end
      FETCH: begin
        if (mem_ack_i) begin
          fwd     = 1'b1;
          store   = !(inv_i || inv_pend_q);
          state_d = IDLE;
        end
      end
      PREF: begin
        if (mem_ack_i) begin
          fwd     = cpu_stb_i && (cpu_adr_i == mem_adr_q);
          store   = !(inv_i || inv_pend_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_ack_o = hit_ack_q || fwd;
  assign cpu_dat_o = fwd ? mem_dat_i : dat_q;
  assign mem_stb_o = mem_stb_q;
  assign mem_adr_o = mem_adr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      valid_q      <= '0;
      hit_ack_q    <= 1'b0;
      ack_prev_q   <= 1'b0;
      dmem_q       <= 1'b0;
      inv_pend_q   <= 1'b0;
      dat_q        <= '0;
      mem_stb_q    <= 1'b0;
      mem_adr_q    <= '0;
    end else begin
      state_q    <= state_d;
      hit_ack_q  <= hit_now;
      ack_prev_q <= cpu_ack_o;
      dmem_q     <= dmem_req_i;
      if (hit_now) dat_q <= data_q[cpu_idx];
      if (start_fetch) begin
        mem_stb_q <= 1'b1;
        mem_adr_q <= cpu_adr_i;
        if (new_line) begin
          tag_q        <= cpu_tag;
          line_valid_q <= 1'b1;
        end
      end else if (start_pref) begin
        mem_stb_q <= 1'b1;
        mem_adr_q <= {tag_q, pf_idx};
      end else if (mem_ack_i && state_q != IDLE) begin
        mem_stb_q <= 1'b0;
      end
      if (new_line || inv_i) valid_q <= '0;
      else if (store) valid_q[mem_idx] <= 1'b1;
      // An invalidate seen mid-transfer poisons the word that is still on its way.
      if (state_q == IDLE || mem_ack_i) inv_pend_q <= 1'b0;
      else if (inv_i) inv_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) data_q[mem_idx] <= mem_dat_i;
  end

endmodule

// File: tb/tb_wb_iprefetch.sv
// Self-checking bench for wb_iprefetch: vector table, directed corner cases, random traffic.
module tb_wb_iprefetch;
  localparam int ADRW  = 22;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1;
  logic            cpu_stb_i = 1'b0;
  logic [ADRW-1:0] cpu_adr_i = '0;
  logic [31:0]     cpu_dat_o;
  logic            cpu_ack_o;
  logic            mem_stb_o;
  logic [ADRW-1:0] mem_adr_o;
  logic [31:0]     mem_dat_i = '0;
  logic            mem_ack_i = 1'b0;
  logic            dmem_req_i = 1'b0;
  logic            inv_i = 1'b0;

  wb_iprefetch #(.DEPTH(DEPTH), .ADRW(ADRW)) dut (
    .clk_i(clk), .rst_i(rst_i), .cpu_stb_i(cpu_stb_i), .cpu_adr_i(cpu_adr_i),
    .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .mem_stb_o(mem_stb_o),
    .mem_adr_o(mem_adr_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .dmem_req_i(dmem_req_i), .inv_i(inv_i)
  );

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int mcnt = 0;
  int ver = 0;
  int obs_ver = 0;
  bit rnd_lat = 0;
  logic rst_nxt = 1'b1;
  logic [ADRW-1:0] mlog[$];
  logic obs_ack, obs_mstb, obs_mack;
  logic [31:0] obs_dat;
  logic [ADRW-1:0] obs_madr;
  logic prev_mstb = 0, prev_mack = 0;
  logic [ADRW-1:0] prev_madr = '0;

  typedef struct {
    logic [ADRW-1:0] adr;
    int idle;
    int lat;
    int exp_n;
    int exp_reads;
    int idle_after;
    bit pf;
  } vec_t;
  vec_t tbl[10];

  // Memory contents; a version bump models code being rewritten behind an invalidate.
  function automatic logic [31:0] mem_word(input logic [ADRW-1:0] a, input int v);
    if (a == 22'h10 && v == 0) return 32'hDEADBEEF;
    return {a[9:0], a} ^ (32'h9E3779B9 * (v + 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic stb, input logic [ADRW-1:0] adr, input logic dmem, input logic inv);
    @(posedge clk);
    #1;
    rst_i = rst_nxt;
    cpu_stb_i = stb;
    cpu_adr_i = adr;
    dmem_req_i = dmem;
    inv_i = inv;
    mem_ack_i = 1'b0;
    mem_dat_i = $urandom;
    if (rst_i) mcnt = 0;
    else if (mem_stb_o) begin
      if (mcnt >= mem_lat) begin
        mem_ack_i = 1'b1;
        mem_dat_i = mem_word(mem_adr_o, ver);
        mcnt = 0;
        if (rnd_lat) mem_lat = $urandom_range(0, 6);
      end else mcnt++;
    end
    #1;
    obs_ack = cpu_ack_o;
    obs_dat = cpu_dat_o;
    obs_mstb = mem_stb_o;
    obs_madr = mem_adr_o;
    obs_mack = mem_ack_i;
    obs_ver = ver;
    if (!rst_i) begin
      if (prev_mstb && !prev_mack) begin
        chk("mem_stb_hold", obs_mstb, 1);
        chk("mem_adr_hold", obs_madr, prev_madr);
      end
      if (prev_mack) chk("mem_idle_gap", obs_mstb, 0);
      if (obs_ack) chk("ack_needs_stb", stb, 1);
      if (obs_mstb && obs_mack) mlog.push_back(obs_madr);
      prev_mstb = obs_mstb;
      prev_mack = obs_mstb && obs_mack;
      prev_madr = obs_madr;
      if (inv) ver++;
    end else begin
      prev_mstb = 0;
      prev_mack = 0;
    end
  endtask

  task automatic idle(input int n, input logic dmem);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, dmem, 1'b0);
  endtask

  task automatic run_req(input logic [ADRW-1:0] adr, input logic dmem, output int n,
                         output int reads, output logic [31:0] dat, output logic with_mack,
                         output int first_stb, output logic [ADRW-1:0] first_adr);
    int base;
    base = mlog.size();
    n = -1;
    first_stb = -1;
    first_adr = '0;
    dat = '0;
    with_mack = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, adr, dmem, 1'b0);
      if (obs_mstb && first_stb < 0) begin
        first_stb = i;
        first_adr = obs_madr;
      end
      if (obs_ack) begin
        n = i;
        dat = obs_dat;
        with_mack = obs_mack;
        break;
      end
    end
    if (n < 0) chk("req_timeout", 0, 1);
    cyc(1'b0, adr, dmem, 1'b0);
    reads = mlog.size() - base;
  endtask

  initial begin
    int n, reads, fs, base, found, cnt;
    logic [31:0] dat;
    logic wm;
    logic [ADRW-1:0] fa, a, ra;
    logic [ADRW-1:0] expq[$];
    logic [1:0] wl;
    logic dm, iv;

    tbl[0] = '{22'h10, 2, 20, 21, 1, 100, 1'b1};
    tbl[1] = '{22'h12, 0, 20, 1, 0, 0, 1'b0};
    tbl[2] = '{22'h13, 0, 20, 1, 0, 0, 1'b0};
    tbl[3] = '{22'h11, 0, 20, 1, 0, 0, 1'b0};
    tbl[4] = '{22'h10, 0, 20, 1, 0, 0, 1'b0};
    tbl[5] = '{22'h23, 2, 5, 6, 1, 60, 1'b1};
    tbl[6] = '{22'h20, 0, 5, 1, 0, 0, 1'b0};
    tbl[7] = '{22'h22, 0, 5, 1, 0, 0, 1'b0};
    tbl[8] = '{22'h3FFFFD, 2, 0, 1, 1, 20, 1'b1};
    tbl[9] = '{22'h3FFFFE, 0, 0, 1, 0, 0, 1'b0};

    rst_nxt = 1'b1;
    idle(3, 1'b0);
    chk("rst_cpu_ack", obs_ack, 0);
    chk("rst_cpu_dat", obs_dat, 0);
    chk("rst_mem_stb", obs_mstb, 0);
    chk("rst_mem_adr", obs_madr, 0);
    rst_nxt = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b0);
      if (obs_mstb) cnt++;
    end
    chk("no_pf_after_rst", cnt, 0);

    foreach (tbl[k]) begin
      mem_lat = tbl[k].lat;
      idle(tbl[k].idle, 1'b0);
      run_req(tbl[k].adr, 1'b0, n, reads, dat, wm, fs, fa);
      chk("vec_latency", n, tbl[k].exp_n);
      chk("vec_reads", reads, tbl[k].exp_reads);
      chk("vec_data", dat, mem_word(tbl[k].adr, ver));
      if (tbl[k].exp_reads == 1) begin
        chk("vec_mem_stb_t1", fs, 1);
        chk("vec_mem_adr", fa, tbl[k].adr);
        chk("vec_ack_with_mem_ack", wm, 1);
      end
      if (tbl[k].pf) begin
        base = mlog.size();
        idle(tbl[k].idle_after, 1'b0);
        expq.delete();
        for (int w = 0; w < DEPTH; w++) begin
          wl = w[1:0];
          a = {tbl[k].adr[ADRW-1:2], wl};
          if (a != tbl[k].adr) expq.push_back(a);
        end
        chk("pf_count", mlog.size() - base, expq.size());
        for (int j = 0; j < expq.size(); j++)
          if (base + j < mlog.size()) chk("pf_order", mlog[base + j], expq[j]);
      end
    end

    // Demand fetch that merges with a prefetch of the same word.
    mem_lat = 10;
    run_req(22'h40, 1'b0, n, reads, dat, wm, fs, fa);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      idle(1, 1'b0);
      if (obs_mstb && obs_madr == 22'h43) found = 1;
    end
    chk("merge_pf_seen", found, 1);
    run_req(22'h43, 1'b0, n, reads, dat, wm, fs, fa);
    chk("merge_reads", reads, 1);
    chk("merge_ack_with_mem_ack", wm, 1);
    chk("merge_data", dat, mem_word(22'h43, ver));
    base = mlog.size();
    idle(30, 1'b0);
    chk("merge_no_more_reads", mlog.size() - base, 0);

    // Data-port activity blocks prefetch; release starts it two cycles later.
    mem_lat = 3;
    run_req(22'h80, 1'b1, n, reads, dat, wm, fs, fa);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1, 1'b1);
      if (obs_mstb) cnt++;
    end
    chk("dmem_blocks_pf", cnt, 0);
    fs = -1;
    for (int i = 0; i < 20 && fs < 0; i++) begin
      idle(1, 1'b0);
      if (obs_mstb) begin
        fs = i;
        fa = obs_madr;
      end
    end
    chk("dmem_release_delay", fs, 2);
    chk("dmem_release_adr", fa, 22'h81);
    idle(40, 1'b0);

    // Invalidate during a prefetch: the prefetched word must be refetched.
    mem_lat = 8;
    run_req(22'h100, 1'b0, n, reads, dat, wm, fs, fa);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      idle(1, 1'b0);
      if (obs_mstb && obs_madr == 22'h101) found = 1;
    end
    chk("inv_pf_seen", found, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      idle(1, 1'b0);
      if (obs_mack) found = 1;
    end
    chk("inv_pf_done", found, 1);
    run_req(22'h101, 1'b0, n, reads, dat, wm, fs, fa);
    chk("inv_refetch_reads", reads, 1);
    chk("inv_refetch_adr", fa, 22'h101);
    chk("inv_refetch_latency", n, 9);
    chk("inv_refetch_data", dat, mem_word(22'h101, ver));
    idle(40, 1'b0);

    // Random traffic against the memory-image model.
    rnd_lat = 1;
    for (int r = 0; r < 400; r++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        dm = ($urandom_range(0, 9) < 3);
        iv = ($urandom_range(0, 99) < 3);
        cyc(1'b0, '0, dm, iv);
      end
      ra = 22'h200 + 22'($urandom_range(0, 11));
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
        dm = ($urandom_range(0, 9) < 3);
        iv = ($urandom_range(0, 99) < 3);
        cyc(1'b1, ra, dm, iv);
        if (obs_ack) begin
          found = 1;
          chk("rnd_data", obs_dat, mem_word(ra, obs_ver));
        end
      end
      if (found == 0) chk("rnd_timeout", 0, 1);
    end
    rnd_lat = 0;
    idle(2, 1'b0);

    // Reset in the middle of a demand read.
    mem_lat = 50;
    idle(20, 1'b0);
    cyc(1'b1, 22'h300, 1'b0, 1'b0);
    cyc(1'b1, 22'h300, 1'b0, 1'b0);
    chk("rst_mid_stb_before", obs_mstb, 1);
    rst_nxt = 1'b1;
    cyc(1'b1, 22'h300, 1'b0, 1'b0);
    rst_nxt = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst_mid_stb", obs_mstb, 0);
    chk("rst_mid_adr", obs_madr, 0);
    chk("rst_mid_ack", obs_ack, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1, 1'b0);
      if (obs_mstb) cnt++;
    end
    chk("rst_mid_no_pf", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
